// File: rtl/apb_event_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_event_slave
// Brief    : Write-only APB completer for the event-driven APB master.
//            Decodes three event addresses, latches write data per event,
//            keeps a wrapping per-event write counter, and stretches each
//            transfer by WAIT_CYCLES wait states on pready_o.
// Revision : 1.0 - initial release
// ============================================================================
module apb_event_slave #(
   parameter int WAIT_CYCLES = 1,   // wait states per transfer, 0..15
   parameter int CNT_W       = 8    // width of each per-event write counter
) (
   input  logic             clk,
   input  logic             rst,          // asynchronous, active-low
   input  logic             psel_i,
   input  logic             penable_i,
   input  logic [31:0]      paddr_i,
   input  logic             pwrite_i,
   input  logic [31:0]      pwdata_i,
   input  logic             err_clr_i,
   output logic             pready_o,
   output logic [31:0]      reg_a_o,
   output logic [31:0]      reg_b_o,
   output logic [31:0]      reg_c_o,
   output logic [CNT_W-1:0] cnt_a_o,
   output logic [CNT_W-1:0] cnt_b_o,
   output logic [CNT_W-1:0] cnt_c_o,
   output logic [2:0]       wr_strobe_o,
   output logic             decode_err_o
);

   localparam logic [31:0]      c_addr_a    = 32'h1000_1000;
   localparam logic [31:0]      c_addr_b    = 32'h2000_2000;
   localparam logic [31:0]      c_addr_c    = 32'h3000_3000;
   localparam logic [3:0]       c_wait_load = 4'(WAIT_CYCLES);
   localparam bit               c_has_wait  = (WAIT_CYCLES > 0);
   localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   state_t           r_state;
   logic [3:0]       r_wait_cnt;
   logic             r_pready;
   logic [31:0]      r_reg_a;
   logic [31:0]      r_reg_b;
   logic [31:0]      r_reg_c;
   logic [CNT_W-1:0] r_cnt_a;
   logic [CNT_W-1:0] r_cnt_b;
   logic [CNT_W-1:0] r_cnt_c;
   logic [2:0]       r_strobe;
   logic             r_decode_err;

   logic w_setup;
   logic w_commit;
   logic w_hit_a;
   logic w_hit_b;
   logic w_hit_c;
   logic w_miss;

   assign w_setup  = psel_i & ~penable_i;
   // ready is part of the commit term, so a transfer can only land on its
   // final access cycle once the wait sequence has finished
   assign w_commit = psel_i & penable_i & r_pready & pwrite_i;
   assign w_hit_a  = (paddr_i == c_addr_a);
   assign w_hit_b  = (paddr_i == c_addr_b);
   assign w_hit_c  = (paddr_i == c_addr_c);
   assign w_miss   = ~(w_hit_a | w_hit_b | w_hit_c);

   // Wait-state sequencer: holds ready low for WAIT_CYCLES cycles after setup
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= 4'd0;
         r_pready   <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_pready <= 1'b1;
               if (w_setup && c_has_wait) begin
                  r_wait_cnt <= c_wait_load;
                  r_state    <= ST_STALL;
                  r_pready   <= 1'b0;
               end
            end
            ST_STALL: begin
               // a deselect aborts the transfer; setups seen here are ignored
               if (!psel_i || (r_wait_cnt == 4'd1)) begin
                  r_wait_cnt <= 4'd0;
                  r_state    <= ST_IDLE;
                  r_pready   <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
                  r_pready   <= 1'b0;
               end
            end
            default: begin
               r_wait_cnt <= 4'd0;
               r_state    <= ST_IDLE;
               r_pready   <= 1'b1;
            end
         endcase
      end
   end

   // Commit path: latch data, bump counter and pulse strobe of the decoded event
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_reg_a  <= 32'd0;
         r_reg_b  <= 32'd0;
         r_reg_c  <= 32'd0;
         r_cnt_a  <= '0;
         r_cnt_b  <= '0;
         r_cnt_c  <= '0;
         r_strobe <= 3'b000;
      end else begin
         r_strobe <= 3'b000;
         if (w_commit) begin
            if (w_hit_a) begin
               r_reg_a     <= pwdata_i;
               r_cnt_a     <= r_cnt_a + c_cnt_one;
               r_strobe[0] <= 1'b1;
            end
            if (w_hit_b) begin
               r_reg_b     <= pwdata_i;
               r_cnt_b     <= r_cnt_b + c_cnt_one;
               r_strobe[1] <= 1'b1;
            end
            if (w_hit_c) begin
               r_reg_c     <= pwdata_i;
               r_cnt_c     <= r_cnt_c + c_cnt_one;
               r_strobe[2] <= 1'b1;
            end
         end
      end
   end

   // Sticky decode error; a new error outranks a simultaneous clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_decode_err <= 1'b0;
      end else if (w_commit && w_miss) begin
         r_decode_err <= 1'b1;
      end else if (err_clr_i) begin
         r_decode_err <= 1'b0;
      end
   end

   assign pready_o     = r_pready;
   assign reg_a_o      = r_reg_a;
   assign reg_b_o      = r_reg_b;
   assign reg_c_o      = r_reg_c;
   assign cnt_a_o      = r_cnt_a;
   assign cnt_b_o      = r_cnt_b;
   assign cnt_c_o      = r_cnt_c;
   assign wr_strobe_o  = r_strobe;
   assign decode_err_o = r_decode_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_event_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_event_slave
// Brief    : Scoreboard bench for apb_event_slave (WAIT_CYCLES=2, CNT_W=8).
//            The driver pushes the expected post-commit state for every
//            mapped write; a monitor pops and compares on each strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_event_slave;

   localparam int C_WAIT = 2;
   localparam int C_CW   = 8;

   logic            clk;
   logic            rst;
   logic            psel;
   logic            penable;
   logic [31:0]     paddr;
   logic            pwrite;
   logic [31:0]     pwdata;
   logic            err_clr;
   logic            pready;
   logic [31:0]     reg_a;
   logic [31:0]     reg_b;
   logic [31:0]     reg_c;
   logic [C_CW-1:0] cnt_a;
   logic [C_CW-1:0] cnt_b;
   logic [C_CW-1:0] cnt_c;
   logic [2:0]      wr_strobe;
   logic            decode_err;

   typedef struct packed {
      logic [2:0]      strobe;
      logic [31:0]     ra;
      logic [31:0]     rb;
      logic [31:0]     rc;
      logic [C_CW-1:0] ca;
      logic [C_CW-1:0] cb;
      logic [C_CW-1:0] cc;
   } exp_t;

   exp_t            sb_q[$];
   logic [31:0]     m_reg[3];
   logic [C_CW-1:0] m_cnt[3];
   int              checks = 0;
   int              errors = 0;
   bit              clr_on_commit = 0;

   apb_event_slave #(.WAIT_CYCLES(C_WAIT), .CNT_W(C_CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .psel_i       (psel),
      .penable_i    (penable),
      .paddr_i      (paddr),
      .pwrite_i     (pwrite),
      .pwdata_i     (pwdata),
      .err_clr_i    (err_clr),
      .pready_o     (pready),
      .reg_a_o      (reg_a),
      .reg_b_o      (reg_b),
      .reg_c_o      (reg_c),
      .cnt_a_o      (cnt_a),
      .cnt_b_o      (cnt_b),
      .cnt_c_o      (cnt_c),
      .wr_strobe_o  (wr_strobe),
      .decode_err_o (decode_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Current model state as a comparable record (strobe supplied by caller)
   function automatic exp_t model_snap(input logic [2:0] s);
      exp_t e;
      e.strobe = s;
      e.ra = m_reg[0]; e.rb = m_reg[1]; e.rc = m_reg[2];
      e.ca = m_cnt[0]; e.cb = m_cnt[1]; e.cc = m_cnt[2];
      return e;
   endfunction

   // Compare all register/counter outputs against the model
   task automatic chk_state(input string tag);
      chk({tag, "_reg_a"}, reg_a, m_reg[0]);
      chk({tag, "_reg_b"}, reg_b, m_reg[1]);
      chk({tag, "_reg_c"}, reg_c, m_reg[2]);
      chk({tag, "_cnt_a"}, 32'(cnt_a), 32'(m_cnt[0]));
      chk({tag, "_cnt_b"}, 32'(cnt_b), 32'(m_cnt[1]));
      chk({tag, "_cnt_c"}, 32'(cnt_c), 32'(m_cnt[2]));
   endtask

   // Monitor: every strobe must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst && wr_strobe != 3'b000) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got %b expected none", wr_strobe);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_strobe", 32'(wr_strobe), 32'(e.strobe));
            chk("sb_reg_a", reg_a, e.ra);
            chk("sb_reg_b", reg_b, e.rb);
            chk("sb_reg_c", reg_c, e.rc);
            chk("sb_cnt_a", 32'(cnt_a), 32'(e.ca));
            chk("sb_cnt_b", 32'(cnt_b), 32'(e.cb));
            chk("sb_cnt_c", 32'(cnt_c), 32'(e.cc));
         end
      end
   end

   // One APB transfer; returns the number of access cycles with ready low.
   // Called just after a rising edge; returns just after the commit edge with
   // the bus still selected so a following call forms a back-to-back setup.
   task automatic xfer(input logic [31:0] a, input logic [31:0] d, input bit w,
                       output int low);
      int idx;
      psel = 1'b1; penable = 1'b0; paddr = a; pwdata = d; pwrite = w;
      @(posedge clk); #1;
      penable = 1'b1;
      low = 0;
      while (!pready && low < 40) begin
         low++;
         @(posedge clk); #1;
      end
      if (!pready) begin
         checks++; errors++;
         $display("FAIL ready_timeout: got 0 expected 1");
      end
      idx = (a == 32'h1000_1000) ? 0 : (a == 32'h2000_2000) ? 1 :
            (a == 32'h3000_3000) ? 2 : -1;
      if (w && idx >= 0) begin
         m_reg[idx] = d;
         m_cnt[idx] = m_cnt[idx] + 1'b1;
         sb_q.push_back(model_snap(3'(1 << idx)));
      end
      err_clr = clr_on_commit;
      @(posedge clk); #1;
      err_clr = 1'b0;
   endtask

   task automatic bus_idle(input int n);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_reg[i] = 32'd0;
         m_cnt[i] = '0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int low;
      model_reset();
      rst = 1'b0; err_clr = 1'b0;
      psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;

      // Reset with random bus activity
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         psel = 1'($urandom); penable = 1'($urandom); pwrite = 1'($urandom);
         paddr = $urandom; pwdata = $urandom; err_clr = 1'($urandom);
      end
      chk("rst_pready", 32'(pready), 32'd1);
      chk("rst_strobe", 32'(wr_strobe), 32'd0);
      chk("rst_err", 32'(decode_err), 32'd0);
      chk_state("rst");
      err_clr = 1'b0;
      bus_idle(1);
      rst = 1'b1;
      bus_idle(2);

      // Single write with wait states
      xfer(32'h1000_1000, 32'hDEAD_CAFE, 1'b1, low);
      chk("single_low_cycles", low, C_WAIT);
      bus_idle(1);
      chk("single_strobe_cleared", 32'(wr_strobe), 32'd0);

      // Back-to-back writes to B then C
      xfer(32'h2000_2000, 32'h0000_0001, 1'b1, low);
      chk("b2b_b_low_cycles", low, C_WAIT);
      xfer(32'h3000_3000, 32'h0000_0002, 1'b1, low);
      chk("b2b_c_low_cycles", low, C_WAIT);
      bus_idle(2);
      chk_state("b2b");

      // Unmapped write, set-beats-clear, then clear alone
      xfer(32'h4000_0000, 32'h1234_5678, 1'b1, low);
      bus_idle(1);
      chk("unmapped_err_set", 32'(decode_err), 32'd1);
      chk_state("unmapped");
      clr_on_commit = 1'b1;
      xfer(32'h5000_0000, 32'h8765_4321, 1'b1, low);
      clr_on_commit = 1'b0;
      bus_idle(1);
      chk("set_wins_over_clr", 32'(decode_err), 32'd1);
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("err_cleared", 32'(decode_err), 32'd0);

      // Read transfer to a mapped address changes nothing
      xfer(32'h1000_1000, 32'hFFFF_FFFF, 1'b0, low);
      chk("read_low_cycles", low, C_WAIT);
      bus_idle(1);
      chk("read_err", 32'(decode_err), 32'd0);
      chk_state("read");

      // Abort: psel drops during STALL
      psel = 1'b1; penable = 1'b0; paddr = 32'h1000_1000; pwdata = 32'hAAAA_5555; pwrite = 1'b1;
      @(posedge clk); #1;
      chk("abort_stall_entered", 32'(pready), 32'd0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      chk("abort_ready_back", 32'(pready), 32'd1);
      bus_idle(3);
      chk_state("abort");

      // Reset asserted mid-STALL
      psel = 1'b1; penable = 1'b0; paddr = 32'h2000_2000; pwdata = 32'h5555_AAAA; pwrite = 1'b1;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst_mid_pready", 32'(pready), 32'd1);
      chk("rst_mid_strobe", 32'(wr_strobe), 32'd0);
      chk_state("rst_mid");
      bus_idle(2);
      rst = 1'b1;
      bus_idle(2);

      // Counter wrap on C: 256 writes from zero
      for (int i = 0; i < 256; i++) begin
         xfer(32'h3000_3000, 32'hC000_0000 + 32'(i), 1'b1, low);
      end
      bus_idle(2);
      chk("wrap_cnt_c", 32'(cnt_c), 32'd0);
      chk("wrap_reg_c", reg_c, 32'hC000_00FF);
      chk_state("wrap");

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
